// File: rtl/counter_sched.sv
// ============================================================================
// Module  : counter_sched
// Brief   : Round-robin scheduler sharing one WIDTH-bit up-counter among
//           N_REQ requesters. Optional abort-on-request-drop is enabled by
//           defining COUNTER_SCHED_ABORT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_sched #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] len,
    input  logic                   hold,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [WIDTH-1:0]       count,
    output logic                   done,
    output logic                   aborted
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_REQ-1:0] r_gnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_target;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;
    logic             r_done;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_next_ptr;
    int               w_idx;

    // Scan downward so the last hit is the one closest to ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
    end

    assign w_next_ptr = (r_win == PW'(N_REQ - 1)) ? '0 : r_win + PW'(1);

`ifdef COUNTER_SCHED_ABORT_EN
    logic r_aborted;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_count  <= '0;
            r_target <= '0;
            r_ptr    <= '0;
            r_win    <= '0;
            r_done   <= 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef COUNTER_SCHED_ABORT_EN
            r_aborted <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_RUN;
                        r_gnt    <= N_REQ'(1) << w_win;
                        r_busy   <= 1'b1;
                        r_count  <= '0;
                        r_target <= len[w_win*WIDTH +: WIDTH];
                        r_win    <= w_win;
                    end
                end
                S_RUN: begin
`ifdef COUNTER_SCHED_ABORT_EN
                    if (!req[r_win]) begin
                        r_state   <= S_IDLE;
                        r_gnt     <= '0;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                        r_ptr     <= w_next_ptr;
                    end else
`endif
                    if (!hold) begin
                        if (r_count == r_target) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_count <= r_count + WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_next_ptr;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign busy  = r_busy;
    assign count = r_count;
    assign done  = r_done;
`ifdef COUNTER_SCHED_ABORT_EN
    assign aborted = r_aborted;
`else
    assign aborted = 1'b0;
`endif

endmodule

`default_nettype wire
